// File: rtl/instruction_fetch_if.sv
// Fetch-unit signal bundle: core-side control, instruction-memory bus and
// decode-stage outputs. The master modport is the fetch unit itself.
interface instruction_fetch_if #(
  parameter int unsigned XLEN = 32
);
  logic            phase_fetch;
  logic            jump_en;
  logic [XLEN-1:0] jump_addr;
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ack;
  logic [31:0]     imem_rdata;
  logic [31:0]     inst;
  logic [XLEN-1:0] curr_pc_fd;
  logic [XLEN-1:0] next_pc_fd;
  logic            inst_valid;
  logic            misalign_fd;
  logic            stall_fetch;

  modport master (
    input  phase_fetch, jump_en, jump_addr, imem_ack, imem_rdata,
    output imem_req, imem_addr, inst, curr_pc_fd, next_pc_fd,
           inst_valid, misalign_fd, stall_fetch
  );

  modport slave (
    output phase_fetch, jump_en, jump_addr, imem_ack, imem_rdata,
    input  imem_req, imem_addr, inst, curr_pc_fd, next_pc_fd,
           inst_valid, misalign_fd, stall_fetch
  );
endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch unit: holds the PC, issues one instruction-memory read
// per phase_fetch strobe, and handles PC redirects, including redirects that
// arrive while a read is outstanding (the stale response is dropped and the
// target is re-requested).
module instruction_fetch #(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
  input  logic                clk,
  input  logic                rst,
  instruction_fetch_if.master bus
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  state_t          r_state;
  state_t          w_next_state;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_req_addr;
  logic            r_req_mis;
  logic            r_pend_mis;
  logic            r_kill;
  logic [31:0]     r_inst;
  logic [XLEN-1:0] r_curr_pc;
  logic [XLEN-1:0] r_next_pc;
  logic            r_inst_valid;
  logic            r_misalign;

  logic [XLEN-1:0] w_fa;
  logic            w_mf;
  logic            w_kill_now;
  logic [XLEN-1:0] w_req_plus4;

  // Fetch address/misalign flag and the kill condition for the current cycle
  always_comb begin
    w_fa        = bus.jump_en ? bus.jump_addr : r_pc;
    w_fa[1:0]   = 2'b00;
    w_mf        = bus.jump_en & (|bus.jump_addr[1:0]);
    w_kill_now  = r_kill | bus.jump_en;
    w_req_plus4 = r_req_addr + XLEN'(4);
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (bus.phase_fetch) w_next_state = ST_WAIT;
      ST_WAIT: if (bus.imem_ack && !w_kill_now) w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Output logic: request and stall follow the state, the rest are registered
  always_comb begin
    bus.imem_req    = (r_state == ST_WAIT);
    bus.stall_fetch = (r_state == ST_WAIT);
    bus.imem_addr   = r_req_addr;
    bus.inst        = r_inst;
    bus.curr_pc_fd  = r_curr_pc;
    bus.next_pc_fd  = r_next_pc;
    bus.inst_valid  = r_inst_valid;
    bus.misalign_fd = r_misalign;
  end

  // Datapath: PC, request latch, kill tracking and decode-stage registers.
  // A redirect seen during WAIT is parked in r_pc/r_pend_mis (the PC is not
  // otherwise used while a request is outstanding), so the latest jump wins
  // and is re-requested on the ack that discards the stale response.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc         <= RESET_VECTOR;
      r_req_addr   <= RESET_VECTOR;
      r_req_mis    <= 1'b0;
      r_pend_mis   <= 1'b0;
      r_kill       <= 1'b0;
      r_inst       <= NOP;
      r_curr_pc    <= RESET_VECTOR;
      r_next_pc    <= RESET_VECTOR + XLEN'(4);
      r_inst_valid <= 1'b0;
      r_misalign   <= 1'b0;
    end else begin
      r_inst_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.phase_fetch) begin
            r_req_addr <= w_fa;
            r_req_mis  <= bus.jump_en ? w_mf : r_pend_mis;
            r_pend_mis <= 1'b0;
            r_pc       <= w_fa;
          end else if (bus.jump_en) begin
            r_pc       <= w_fa;
            r_pend_mis <= w_mf;
          end
        end
        ST_WAIT: begin
          if (bus.imem_ack) begin
            if (w_kill_now) begin
              r_req_addr <= bus.jump_en ? w_fa : r_pc;
              r_req_mis  <= bus.jump_en ? w_mf : r_pend_mis;
              r_pc       <= bus.jump_en ? w_fa : r_pc;
              r_pend_mis <= 1'b0;
              r_kill     <= 1'b0;
            end else begin
              r_inst       <= bus.imem_rdata;
              r_curr_pc    <= r_req_addr;
              r_next_pc    <= w_req_plus4;
              r_misalign   <= r_req_mis;
              r_inst_valid <= 1'b1;
              r_pc         <= w_req_plus4;
            end
          end else if (bus.jump_en) begin
            r_kill     <= 1'b1;
            r_pc       <= w_fa;
            r_pend_mis <= w_mf;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch (XLEN=32, RESET_VECTOR=0).
module tb_instruction_fetch;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  instruction_fetch_if #(.XLEN(32)) bus ();

  instruction_fetch #(
    .XLEN         (32),
    .RESET_VECTOR (32'h0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fetch_done(input string tag, input logic [31:0] i, input logic [31:0] pc,
                            input logic [31:0] npc, input logic mis);
    chk({tag, "_valid"}, 64'(bus.inst_valid), 64'd1);
    chk({tag, "_inst"},  64'(bus.inst), 64'(i));
    chk({tag, "_curr"},  64'(bus.curr_pc_fd), 64'(pc));
    chk({tag, "_next"},  64'(bus.next_pc_fd), 64'(npc));
    chk({tag, "_mis"},   64'(bus.misalign_fd), 64'(mis));
  endtask

  initial begin
    rst = 1'b1;
    bus.phase_fetch = 1'b0;
    bus.jump_en     = 1'b0;
    bus.jump_addr   = '0;
    bus.imem_ack    = 1'b0;
    bus.imem_rdata  = '0;

    // Reset state
    tick(); tick();
    rst = 1'b0;
    chk("rst_req",   64'(bus.imem_req), 64'd0);
    chk("rst_stall", 64'(bus.stall_fetch), 64'd0);
    chk("rst_addr",  64'(bus.imem_addr), 64'h0);
    chk("rst_inst",  64'(bus.inst), 64'h13);
    chk("rst_curr",  64'(bus.curr_pc_fd), 64'h0);
    chk("rst_next",  64'(bus.next_pc_fd), 64'h4);
    chk("rst_valid", 64'(bus.inst_valid), 64'd0);
    chk("rst_mis",   64'(bus.misalign_fd), 64'd0);

    // Zero-wait fetch: req at N+1, inst_valid at N+2
    bus.phase_fetch = 1'b1;
    tick();
    bus.phase_fetch = 1'b0;
    chk("zw_req",   64'(bus.imem_req), 64'd1);
    chk("zw_addr",  64'(bus.imem_addr), 64'h0);
    chk("zw_stall", 64'(bus.stall_fetch), 64'd1);
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'h0050_0093;
    tick();
    bus.imem_ack = 1'b0;
    fetch_done("zw", 32'h0050_0093, 32'h0, 32'h4, 1'b0);
    chk("zw_req_drop", 64'(bus.imem_req), 64'd0);
    tick();
    chk("zw_pulse", 64'(bus.inst_valid), 64'd0);

    // Three fetches, ack after three WAIT cycles each
    rst = 1'b1; tick(); rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      bus.phase_fetch = 1'b1;
      tick();
      bus.phase_fetch = 1'b0;
      for (int d = 0; d < 3; d++) begin
        chk("bb_req",   64'(bus.imem_req), 64'd1);
        chk("bb_addr",  64'(bus.imem_addr), 64'(4 * k));
        chk("bb_stall", 64'(bus.stall_fetch), 64'd1);
        chk("bb_novalid", 64'(bus.inst_valid), 64'd0);
        if (d == 2) begin
          bus.imem_ack = 1'b1; bus.imem_rdata = 32'hA000_0000 + 32'(k);
        end
        tick();
      end
      bus.imem_ack = 1'b0;
      fetch_done("bb", 32'hA000_0000 + 32'(k), 32'(4 * k), 32'(4 * k + 4), 1'b0);
      chk("bb_idle", 64'(bus.stall_fetch), 64'd0);
    end

    // Jump one cycle before ack of fetch at 0x8
    rst = 1'b1; tick(); rst = 1'b0;
    bus.jump_en = 1'b1; bus.jump_addr = 32'h8;
    tick();
    bus.jump_en = 1'b0;
    chk("ij_idle", 64'(bus.stall_fetch), 64'd0);
    bus.phase_fetch = 1'b1;
    tick();
    bus.phase_fetch = 1'b0;
    chk("k1_addr", 64'(bus.imem_addr), 64'h8);
    tick();
    bus.jump_en = 1'b1; bus.jump_addr = 32'h100;
    tick();
    bus.jump_en = 1'b0;
    chk("k1_hold_req",  64'(bus.imem_req), 64'd1);
    chk("k1_hold_addr", 64'(bus.imem_addr), 64'h8);
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'hDEAD_BEEF;
    tick();
    bus.imem_ack = 1'b0;
    chk("k1_novalid", 64'(bus.inst_valid), 64'd0);
    chk("k1_inst",    64'(bus.inst), 64'h13);
    chk("k1_curr",    64'(bus.curr_pc_fd), 64'h0);
    chk("k1_rereq",   64'(bus.imem_req), 64'd1);
    chk("k1_raddr",   64'(bus.imem_addr), 64'h100);
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'h1111_1111;
    tick();
    bus.imem_ack = 1'b0;
    fetch_done("k1", 32'h1111_1111, 32'h100, 32'h104, 1'b0);

    // Jump and ack in the same cycle
    bus.phase_fetch = 1'b1;
    tick();
    bus.phase_fetch = 1'b0;
    chk("k2_addr", 64'(bus.imem_addr), 64'h104);
    bus.jump_en = 1'b1; bus.jump_addr = 32'h200;
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'hBAD0_0000;
    tick();
    bus.jump_en = 1'b0; bus.imem_ack = 1'b0;
    chk("k2_novalid", 64'(bus.inst_valid), 64'd0);
    chk("k2_rereq",   64'(bus.imem_req), 64'd1);
    chk("k2_raddr",   64'(bus.imem_addr), 64'h200);
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'h2222_2222;
    tick();
    bus.imem_ack = 1'b0;
    fetch_done("k2", 32'h2222_2222, 32'h200, 32'h204, 1'b0);

    // Misaligned IDLE jump, then fetch carries the flag; following fetch clears it
    bus.jump_en = 1'b1; bus.jump_addr = 32'h102;
    tick();
    bus.jump_en = 1'b0;
    chk("mj_req", 64'(bus.imem_req), 64'd0);
    bus.phase_fetch = 1'b1;
    tick();
    bus.phase_fetch = 1'b0;
    chk("mj_addr", 64'(bus.imem_addr), 64'h100);
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'h3333_3333;
    tick();
    bus.imem_ack = 1'b0;
    fetch_done("mj", 32'h3333_3333, 32'h100, 32'h104, 1'b1);
    bus.phase_fetch = 1'b1;
    tick();
    bus.phase_fetch = 1'b0;
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'h4444_4444;
    tick();
    bus.imem_ack = 1'b0;
    fetch_done("mj2", 32'h4444_4444, 32'h104, 32'h108, 1'b0);

    // Reset mid-WAIT; the late ack must be ignored
    bus.phase_fetch = 1'b1;
    tick();
    bus.phase_fetch = 1'b0;
    chk("rw_req", 64'(bus.imem_req), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rw_req_drop", 64'(bus.imem_req), 64'd0);
    chk("rw_inst",     64'(bus.inst), 64'h13);
    chk("rw_valid",    64'(bus.inst_valid), 64'd0);
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'h5555_5555;
    tick();
    bus.imem_ack = 1'b0;
    chk("rw_late_valid", 64'(bus.inst_valid), 64'd0);
    chk("rw_late_inst",  64'(bus.inst), 64'h13);
    chk("rw_late_stall", 64'(bus.stall_fetch), 64'd0);
    bus.phase_fetch = 1'b1;
    tick();
    bus.phase_fetch = 1'b0;
    chk("rw_pc", 64'(bus.imem_addr), 64'h0);
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'h6666_6666;
    tick();
    bus.imem_ack = 1'b0;
    fetch_done("rw", 32'h6666_6666, 32'h0, 32'h4, 1'b0);

    // Reset dominates phase_fetch and jump_en
    rst = 1'b1; bus.phase_fetch = 1'b1; bus.jump_en = 1'b1; bus.jump_addr = 32'h400;
    tick();
    rst = 1'b0; bus.phase_fetch = 1'b0; bus.jump_en = 1'b0;
    chk("rd_stall", 64'(bus.stall_fetch), 64'd0);
    chk("rd_addr",  64'(bus.imem_addr), 64'h0);
    bus.phase_fetch = 1'b1;
    tick();
    bus.phase_fetch = 1'b0;
    chk("rd_pc", 64'(bus.imem_addr), 64'h0);
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'h13;
    tick();
    bus.imem_ack = 1'b0;

    // PC wrap at the top of the address space
    bus.jump_en = 1'b1; bus.jump_addr = 32'hFFFF_FFFC;
    tick();
    bus.jump_en = 1'b0;
    bus.phase_fetch = 1'b1;
    tick();
    bus.phase_fetch = 1'b0;
    chk("wr_addr", 64'(bus.imem_addr), 64'hFFFF_FFFC);
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'h7777_7777;
    tick();
    bus.imem_ack = 1'b0;
    fetch_done("wr", 32'h7777_7777, 32'hFFFF_FFFC, 32'h0, 1'b0);
    bus.phase_fetch = 1'b1;
    tick();
    bus.phase_fetch = 1'b0;
    chk("wr_next_addr", 64'(bus.imem_addr), 64'h0);
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'h8888_8888;
    tick();
    bus.imem_ack = 1'b0;
    fetch_done("wr2", 32'h8888_8888, 32'h0, 32'h4, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
